mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
Shares the single-port, one-cycle-read-latency image memory between NREQ requesters, for example the edge-detection accelerator and a host/loader port.
- Arbitration is round-robin with an optional bounded lock, so a requester can hold the memory across a burst.
- Read data is routed back with a per-requester valid strobe.
- Sits between the requesters and the memory port (addr/dataR/dataW/en/we) at design top level.

Parameters:
NREQ, 2, number of requesters (2..4).
MAX_LOCK, 64, maximum consecutive accepted transfers a locked owner may keep before forced release (>=1).

Ports:
clk  in  1  clock.
reset  in  1  synchronous, active-high reset.
req  in  NREQ  per-requester transfer request.
lock  in  NREQ  per-requester request to keep ownership after the current grant.
req_we  in  NREQ  per-requester write (1) / read (0).
req_addr  in  NREQ x 16  per-requester word address (halfword_t).
req_wdata  in  NREQ x 32  per-requester write data (word_t).
gnt  out  NREQ  one-hot grant; the transfer is accepted in the cycle req[i] & gnt[i].
rdata  out  32  read data, broadcast to all requesters (equals dataR).
rvalid  out  NREQ  one-hot; rvalid[i]=1 the cycle after requester i's accepted read.
addr  out  16  memory address.
dataW  out  32  memory write data.
dataR  in  32  memory read data, valid one cycle after en & !we.
en  out  1  memory enable.
we  out  1  memory write enable.

Behaviour:
- Reset values:
  - gnt=0, rvalid=0, en=0, we=0, addr=0, dataW=0.
  - Priority pointer = 0, state = ARB, lock_cnt = 0.
  - While reset=1, all outputs are forced to these values.
- Grant timing:
  - Grant is combinational in the request cycle; zero added latency.
  - Read data arrives on rdata with rvalid[i] exactly 1 cycle after acceptance.
  - Back-to-back accepted reads give one word per cycle.
- Memory drive in an accepted cycle:
  - en=1, we=req_we[i], addr=req_addr[i], dataW=req_wdata[i].
  - With no accepted transfer: en=0, we=0, addr=0, dataW=0.
- gnt[i] is asserted only when req[i]=1. At most one gnt bit is high.
- State ARB:
  - Grant goes to the first requesting index at or after the pointer, searching cyclically.
  - After an accepted transfer by i, pointer = (i+1) mod NREQ.
  - If the winner also has lock[i]=1: go to LOCKED with owner=i, lock_cnt=1, and the pointer is not advanced.
- State LOCKED:
  - Only the owner can be granted; other requesters wait with gnt=0.
  - Owner req=1: accepted, lock_cnt increments.
  - Owner req=0: idle cycle, en=0, ownership retained, lock_cnt unchanged.
  - Exit to ARB, pointer=(owner+1) mod NREQ, on either condition:
    - the owner's lock=0 sampled in any cycle (that cycle's transfer is still served if req=1);
    - forced release, when the accepted transfer makes lock_cnt reach MAX_LOCK.
  - After a forced release, the next owner arbitration starts from ARB next cycle.
- Simultaneous events:
  - All requesters asserting in ARB → pointer order.
  - Lock asserted by a non-owner while LOCKED is ignored until it wins in ARB.
- Read tagging:
  - rvalid is registered from (accepted & !we) one-hot.
  - Writes produce no response.
  - Read followed by write on the next cycle is legal; the rvalid for the read still fires.
- Reset mid-operation: a pending rvalid is dropped (rvalid=0 next cycle), lock is released, pointer returns to 0.
- Counters: lock_cnt is $clog2(MAX_LOCK+1) bits and saturates at MAX_LOCK.
- No combinational path from rdata/dataR to gnt.

Decomposition:
- Shared package (img_pkg):
  - halfword_t, word_t.
  - IMG_WORDS=25344, IMG_WIDTH_WORDS=88.
  - arbiter state enum (ARB, LOCKED).
- Natural sub-module: rr_pick, a combinational cyclic priority picker (req vector + pointer → one-hot grant).
- mem_arbiter owns the pointer, the lock FSM, the counters and the rvalid registers.

Test Plan:
- Single read: req[0]=1, req_we=0, req_addr=16'h0058 with memory word 0x0058 = 32'hDEADBEEF → gnt[0]=1 and en=1, addr=16'h0058 in the same cycle; next cycle rvalid=2'b01, rdata=32'hDEADBEEF.
- Round-robin fairness: req=2'b11 continuously, lock=0, 6 cycles → gnt sequence 01,10,01,10,01,10; en=1 every cycle.
- Locked burst: req=2'b11, lock[1]=1 from cycle 0 with pointer=1 → gnt=10 for cycles 0..3; drop lock[1] at cycle 3 → gnt=01 at cycle 4.
- Forced release: MAX_LOCK=4, lock[0]=1, req=2'b11 held → exactly 4 grants to 0, then gnt=10 on the 5th cycle.
- Locked idle: owner 0 in LOCKED drops req while req[1]=1 → en=0, gnt=00 for 3 cycles; lock[0]=0 → gnt=10 next cycle.
- Reset mid-read: accepted read at cycle N, reset=1 at cycle N+1 → rvalid=0, gnt=0, en=0 at N+1; after reset, req=2'b11 → gnt=01 first.

Source files
------------

// File: rtl/img_pkg.sv
// Shared image-memory types and arbiter state encoding.
// Pure declarations; no logic and no flow control here.
package img_pkg;

  typedef logic [15:0] halfword_t;
  typedef logic [31:0] word_t;

  localparam int IMG_WORDS       = 25344;
  localparam int IMG_WIDTH_WORDS = 88;

  typedef enum logic {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

endpackage

// File: rtl/mem_arbiter_rr_pick.sv
// Cyclic priority picker: first requester at or after ptr wins; purely combinational.
// No storage and no backpressure; the caller decides whether the pick is accepted.
module rr_pick #(
  parameter int NREQ = 2,
  parameter int PW   = 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic [PW-1:0]   idx,
  output logic            any
);

  logic [PW-1:0] cand;

  // Scan from the farthest slot back to ptr so the nearest requester is written last.
  always_comb begin
    gnt  = '0;
    idx  = '0;
    any  = 1'b0;
    cand = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      cand = PW'((int'(ptr) + k) % NREQ);
      if (req[cand]) begin
        any = 1'b1;
        idx = cand;
      end
    end
    if (any) begin
      gnt[idx] = 1'b1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter with bounded lock for a single-port, 1-cycle-read memory; grant is same-cycle.
// Losers simply see gnt=0 and must hold req; rvalid follows an accepted read by exactly one cycle.
module mem_arbiter
  import img_pkg::*;
#(
  parameter int NREQ     = 2,
  parameter int MAX_LOCK = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] lock,
  input  logic [NREQ-1:0] req_we,
  input  halfword_t       req_addr  [NREQ],
  input  word_t           req_wdata [NREQ],
  output logic [NREQ-1:0] gnt,
  output word_t           rdata,
  output logic [NREQ-1:0] rvalid,
  output halfword_t       addr,
  output word_t           dataW,
  input  word_t           dataR,
  output logic            en,
  output logic            we
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(MAX_LOCK + 1);

  arb_state_t      state_q, state_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [PW-1:0]   owner_q, owner_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [NREQ-1:0] rvalid_q;

  logic [NREQ-1:0] pick_gnt;
  logic [PW-1:0]   pick_idx;
  logic            pick_any;
  logic [PW-1:0]   win;
  logic            accepted;

  function automatic logic [PW-1:0] next_idx(input logic [PW-1:0] i);
    return (i == PW'(NREQ - 1)) ? '0 : i + PW'(1);
  endfunction

  rr_pick #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_pick (
    .req (req),
    .ptr (ptr_q),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    gnt     = '0;
    win     = '0;

    case (state_q)
      ARB: begin
        if (pick_any) begin
          gnt = pick_gnt;
          win = pick_idx;
          // A one-transfer lock budget is exhausted by the winning transfer itself.
          if (lock[pick_idx] && (MAX_LOCK > 1)) begin
            state_d = LOCKED;
            owner_d = pick_idx;
            cnt_d   = CW'(1);
          end else begin
            ptr_d = next_idx(pick_idx);
          end
        end
      end
      LOCKED: begin
        win = owner_q;
        if (req[owner_q]) begin
          gnt[owner_q] = 1'b1;
          cnt_d = (cnt_q == CW'(MAX_LOCK)) ? cnt_q : cnt_q + CW'(1);
        end
        if (!lock[owner_q] || (req[owner_q] && (cnt_q >= CW'(MAX_LOCK - 1)))) begin
          state_d = ARB;
          ptr_d   = next_idx(owner_q);
          cnt_d   = '0;
        end
      end
      default: state_d = ARB;
    endcase

    if (reset) begin
      gnt = '0;
    end
  end

  always_comb begin
    accepted = |gnt;
    en       = accepted;
    we       = accepted & req_we[win];
    addr     = accepted ? req_addr[win]  : '0;
    dataW    = accepted ? req_wdata[win] : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ARB;
      ptr_q    <= '0;
      owner_q  <= '0;
      cnt_q    <= '0;
      rvalid_q <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      owner_q  <= owner_d;
      cnt_q    <= cnt_d;
      rvalid_q <= gnt & ~req_we;
    end
  end

  // A read accepted just before reset must not surface while reset is held.
  assign rvalid = rvalid_q & {NREQ{~reset}};
  assign rdata  = dataR;

endmodule
